// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NRD read ports, two prioritised write
// ports, optional write bypass, per-register busy scoreboard and a clear sweeper.
module regfile_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*DW-1:0]   o_rd_data,
    output logic [NRD-1:0]      o_rd_busy,
    input  logic                i_we0,
    input  logic                i_we1,
    input  logic [AW-1:0]       i_wa0,
    input  logic [AW-1:0]       i_wa1,
    input  logic [DW-1:0]       i_wd0,
    input  logic [DW-1:0]       i_wd1,
    input  logic                i_iss_en,
    input  logic [AW-1:0]       i_iss_addr,
    input  logic                i_clr_req,
    output logic                o_clr_busy,
    output logic                o_clr_done,
    input  logic [AW-1:0]       i_dbg_addr,
    output logic [DW-1:0]       o_dbg_data
);

    localparam int             DEPTH = 1 << AW;
    localparam logic [AW-1:0]  LAST  = '1;
    localparam logic [AW-1:0]  ONE   = AW'(1);
    localparam logic [AW-1:0]  START = (ZERO_REG != 0) ? ONE : '0;

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [DW-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [AW-1:0]  r_ptr;
    logic           r_done;

    logic           w_idle;
    logic           w_we0;
    logic           w_we1;
    logic           w_iss;
    logic           w_sweep_last;
    logic [AW-1:0]  w_ra;

    // Writes and issues only take effect in IDLE, and never touch the hardwired zero register.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_we0        = i_we0 && w_idle && !((ZERO_REG != 0) && (i_wa0 == '0));
    assign w_we1        = i_we1 && w_idle && !((ZERO_REG != 0) && (i_wa1 == '0));
    assign w_iss        = i_iss_en && w_idle && !((ZERO_REG != 0) && (i_iss_addr == '0));
    assign w_sweep_last = (r_ptr == LAST);

    assign o_clr_busy   = (r_state == ST_SWEEP);
    assign o_clr_done   = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_clr_req) w_next_state = ST_SWEEP;
            ST_SWEEP: if (w_sweep_last) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_SWEEP) && w_sweep_last;
            if (w_idle && i_clr_req) begin
                r_ptr <= START;
            end else if ((r_state == ST_SWEEP) && !w_sweep_last) begin
                r_ptr <= r_ptr + ONE;
            end
        end
    end

    // Port 1 is written after port 0 so it wins a same-address collision; issue is last so it
    // keeps the busy bit set when a new producer is issued over a completing write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else if (r_state == ST_SWEEP) begin
            r_mem[r_ptr]  <= '0;
            r_busy[r_ptr] <= 1'b0;
        end else begin
            if (w_we0) begin
                r_mem[i_wa0]  <= i_wd0;
                r_busy[i_wa0] <= 1'b0;
            end
            if (w_we1) begin
                r_mem[i_wa1]  <= i_wd1;
                r_busy[i_wa1] <= 1'b0;
            end
            if (w_iss) begin
                r_busy[i_iss_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        w_ra      = '0;
        for (int k = 0; k < NRD; k++) begin
            w_ra = i_rd_addr[k*AW +: AW];
            o_rd_data[k*DW +: DW] = r_mem[w_ra];
            o_rd_busy[k]          = r_busy[w_ra];
            if (BYPASS != 0) begin
                if (w_we1 && (i_wa1 == w_ra)) begin
                    o_rd_data[k*DW +: DW] = i_wd1;
                    o_rd_busy[k]          = 1'b0;
                end else if (w_we0 && (i_wa0 == w_ra)) begin
                    o_rd_data[k*DW +: DW] = i_wd0;
                    o_rd_busy[k]          = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                o_rd_data[k*DW +: DW] = '0;
                o_rd_busy[k]          = 1'b0;
            end
        end
    end

    always_comb begin
        o_dbg_data = r_mem[i_dbg_addr];
        if ((ZERO_REG != 0) && (i_dbg_addr == '0)) begin
            o_dbg_data = '0;
        end
    end

endmodule
